// File: rtl/test_status_monitor.sv
// ============================================================================
// Module  : test_status_monitor
// Brief   : Latches per-channel pass/fail/exit reports into one test verdict
//           with watchdog, first-failure capture and cycle count. Optional
//           post-verdict drain delay when TEST_MON_DRAIN_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module test_status_monitor #(
    parameter int NUM_CH       = 4,
    parameter int VAL_W        = 32,
    parameter int CNT_W        = 32,
    parameter int STOP_ON_FAIL = 1,
    parameter int DRAIN_CYCLES = 8,
    localparam int FCH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [CNT_W-1:0]        max_cycles_i,
    input  logic [NUM_CH-1:0]       pass_i,
    input  logic [NUM_CH-1:0]       fail_i,
    input  logic [NUM_CH-1:0]       exit_valid_i,
    input  logic [NUM_CH*VAL_W-1:0] exit_value_i,
    output logic [NUM_CH-1:0]       ch_done_o,
    output logic                    done_o,
    output logic [1:0]              status_o,
    output logic [FCH_W-1:0]        fail_ch_o,
    output logic [VAL_W-1:0]        fail_value_o,
    output logic [CNT_W-1:0]        cycle_cnt_o
);

    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
        $error("NUM_CH out of range");
    end
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 255) begin : g_bad_drain
        $error("DRAIN_CYCLES out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] C_ST_PASS    = 2'b01;
    localparam logic [1:0] C_ST_FAIL    = 2'b10;
    localparam logic [1:0] C_ST_TIMEOUT = 2'b11;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   ch_done_q, ch_done_d;
    logic                any_fail_q, any_fail_d;
    logic                done_q, done_d;
    logic [1:0]          status_q, status_d;
    logic [FCH_W-1:0]    fail_ch_q, fail_ch_d;
    logic [VAL_W-1:0]    fail_value_q, fail_value_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef TEST_MON_DRAIN_EN
    localparam logic [7:0] C_DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
    logic [7:0]          drain_q, drain_d;
`endif

    logic [NUM_CH-1:0]   w_fail_vec;
    logic [NUM_CH-1:0]   w_rep_vec;
    logic [FCH_W-1:0]    w_first_idx;
    logic [VAL_W-1:0]    w_first_val;
    logic [VAL_W-1:0]    w_ch_val;

    // Per-channel report decode; the downward scan leaves the lowest failing index.
    always_comb begin
        w_fail_vec  = '0;
        w_rep_vec   = '0;
        w_first_idx = '0;
        w_first_val = '0;
        w_ch_val    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_ch_val      = exit_value_i[k*VAL_W +: VAL_W];
            w_fail_vec[k] = !ch_done_q[k] &&
                            (fail_i[k] || (exit_valid_i[k] && (w_ch_val != '0)));
            w_rep_vec[k]  = !ch_done_q[k] && (fail_i[k] || exit_valid_i[k] || pass_i[k]);
            if (w_fail_vec[k]) begin
                w_first_idx = FCH_W'(k);
                w_first_val = fail_i[k] ? '1 : w_ch_val;
            end
        end
    end

    logic w_fail_any;
    logic w_complete;
    logic w_timeout;

    always_comb begin
        state_d      = state_q;
        ch_done_d    = ch_done_q;
        any_fail_d   = any_fail_q;
        done_d       = done_q;
        status_d     = status_q;
        fail_ch_d    = fail_ch_q;
        fail_value_d = fail_value_q;
        cnt_d        = cnt_q;
        w_fail_any   = any_fail_q;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
`ifdef TEST_MON_DRAIN_EN
        drain_d      = drain_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (enable_i) state_d = S_RUN;
            end
            S_RUN: begin
                ch_done_d  = ch_done_q | w_rep_vec;
                w_fail_any = any_fail_q | (|w_fail_vec);
                any_fail_d = w_fail_any;
                if (!any_fail_q && (|w_fail_vec)) begin
                    fail_ch_d    = w_first_idx;
                    fail_value_d = w_first_val;
                end
                w_complete = ((STOP_ON_FAIL != 0) && w_fail_any) || (&ch_done_d);
                w_timeout  = (max_cycles_i != '0) && (cnt_q >= max_cycles_i);
                if (w_complete || w_timeout) begin
                    // Completion outranks timeout; the counter freezes on this edge.
                    if (w_complete) status_d = w_fail_any ? C_ST_FAIL : C_ST_PASS;
                    else            status_d = C_ST_TIMEOUT;
`ifdef TEST_MON_DRAIN_EN
                    state_d = S_DRAIN;
                    drain_d = '0;
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
`endif
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
`ifdef TEST_MON_DRAIN_EN
                if (drain_q == C_DRAIN_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + 8'd1;
                end
`else
                state_d = S_DONE;
                done_d  = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            ch_done_q    <= '0;
            any_fail_q   <= 1'b0;
            done_q       <= 1'b0;
            status_q     <= '0;
            fail_ch_q    <= '0;
            fail_value_q <= '0;
            cnt_q        <= '0;
`ifdef TEST_MON_DRAIN_EN
            drain_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ch_done_q    <= ch_done_d;
            any_fail_q   <= any_fail_d;
            done_q       <= done_d;
            status_q     <= status_d;
            fail_ch_q    <= fail_ch_d;
            fail_value_q <= fail_value_d;
            cnt_q        <= cnt_d;
`ifdef TEST_MON_DRAIN_EN
            drain_q      <= drain_d;
`endif
        end
    end

    assign ch_done_o    = ch_done_q;
    assign done_o       = done_q;
    assign status_o     = status_q;
    assign fail_ch_o    = fail_ch_q;
    assign fail_value_o = fail_value_q;
    assign cycle_cnt_o  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_test_status_monitor.sv
// ============================================================================
// Module  : tb_test_status_monitor
// Brief   : Directed self-checking bench for test_status_monitor (two
//           instances: STOP_ON_FAIL=1 and STOP_ON_FAIL=0 sharing stimulus).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_test_status_monitor;

    localparam int NCH = 4;
    localparam int VW  = 32;
    localparam int CW  = 32;
`ifdef TEST_MON_DRAIN_EN
    localparam int DRAIN_LAT = 8;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic [CW-1:0]     max_cycles = '0;
    logic [NCH-1:0]    pass = '0;
    logic [NCH-1:0]    fail = '0;
    logic [NCH-1:0]    exit_valid = '0;
    logic [NCH*VW-1:0] exit_value = '0;

    logic [NCH-1:0]    ch_done_a, ch_done_b;
    logic              done_a, done_b;
    logic [1:0]        status_a, status_b;
    logic [1:0]        fail_ch_a, fail_ch_b;
    logic [VW-1:0]     fail_value_a, fail_value_b;
    logic [CW-1:0]     cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    test_status_monitor #(.NUM_CH(NCH), .VAL_W(VW), .CNT_W(CW),
                          .STOP_ON_FAIL(1), .DRAIN_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .max_cycles_i(max_cycles),
        .pass_i(pass), .fail_i(fail), .exit_valid_i(exit_valid),
        .exit_value_i(exit_value), .ch_done_o(ch_done_a), .done_o(done_a),
        .status_o(status_a), .fail_ch_o(fail_ch_a), .fail_value_o(fail_value_a),
        .cycle_cnt_o(cnt_a));

    test_status_monitor #(.NUM_CH(NCH), .VAL_W(VW), .CNT_W(CW),
                          .STOP_ON_FAIL(0), .DRAIN_CYCLES(8)) dut_nostop (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .max_cycles_i(max_cycles),
        .pass_i(pass), .fail_i(fail), .exit_valid_i(exit_valid),
        .exit_value_i(exit_value), .ch_done_o(ch_done_b), .done_o(done_b),
        .status_o(status_b), .fail_ch_o(fail_ch_b), .fail_value_o(fail_value_b),
        .cycle_cnt_o(cnt_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        pass = '0; fail = '0; exit_valid = '0; exit_value = '0; enable = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic start_run();
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    // Checks done_o on the verdict edge and after any drain delay on instance A.
    task automatic wait_done_a(input string tag);
`ifdef TEST_MON_DRAIN_EN
        chk({tag, "_pre"}, done_a, 0);
        repeat (DRAIN_LAT - 1) tick();
        chk({tag, "_drain_last"}, done_a, 0);
        tick();
`endif
        chk(tag, done_a, 1);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_done", done_a, 0);
        chk("rst_status", status_a, 0);
        chk("rst_chdone", ch_done_a, 0);
        chk("rst_cnt", cnt_a, 0);
        tick();
        chk("idle_cnt", cnt_a, 0);

        // 1: all pass at RUN cycles 3,5,5,9
        start_run();
        for (int c = 0; c <= 9; c++) begin
            pass = (c == 3) ? 4'b0001 : (c == 5) ? 4'b0110 : (c == 9) ? 4'b1000 : 4'b0000;
            tick();
            if (c == 5) chk("t1_chdone_mid", ch_done_a, 4'b0111);
            if (c == 8) chk("t1_notdone", done_a, 0);
        end
        pass = '0;
        chk("t1_chdone", ch_done_a, 4'hF);
        chk("t1_status", status_a, 2'b01);
        chk("t1_cnt", cnt_a, 9);
        wait_done_a("t1_done");
        tick(); tick();
        chk("t1_cnt_frozen", cnt_a, 9);

        // 2: fail on ch1 and nonzero exit on ch2 on the same edge
        do_reset();
        start_run();
        exit_valid = 4'b0100;
        exit_value[2*VW +: VW] = 32'd5;
        fail = 4'b0010;
        tick();
        exit_valid = '0; fail = '0; exit_value = '0;
        chk("t2_status", status_a, 2'b10);
        chk("t2_fail_ch", fail_ch_a, 1);
        chk("t2_fail_val", fail_value_a, 32'hFFFF_FFFF);
        chk("t2_chdone", ch_done_a, 4'b0110);
        wait_done_a("t2_done");
        pass = 4'hF;
        tick();
        pass = '0;
        chk("t2_chdone_after", ch_done_a, 4'b0110);
        chk("t2_status_after", status_a, 2'b10);

        // 3: STOP_ON_FAIL=0 waits for every channel
        do_reset();
        start_run();
        exit_valid = 4'b0001;
        exit_value[0 +: VW] = 32'd7;
        tick();
        exit_valid = '0; exit_value = '0;
        chk("t3_nostop_done_early", done_b, 0);
        chk("t3_nostop_status_early", status_b, 2'b00);
        chk("t3_nostop_fail_val_early", fail_value_b, 7);
        chk("t3_stop_status", status_a, 2'b10);
        repeat (9) tick();
        chk("t3_nostop_done_wait", done_b, 0);
        pass = 4'b1110;
        tick();
        pass = '0;
        chk("t3_status", status_b, 2'b10);
        chk("t3_fail_ch", fail_ch_b, 0);
        chk("t3_fail_val", fail_value_b, 7);
        chk("t3_chdone", ch_done_b, 4'hF);
`ifdef TEST_MON_DRAIN_EN
        repeat (DRAIN_LAT) tick();
`endif
        chk("t3_done", done_b, 1);

        // 4a: watchdog timeout at count 20
        do_reset();
        max_cycles = 32'd20;
        start_run();
        repeat (20) tick();
        chk("t4_cnt20", cnt_a, 20);
        chk("t4_notdone", status_a, 2'b00);
        tick();
        chk("t4_status", status_a, 2'b11);
        chk("t4_cnt_frozen", cnt_a, 20);
        wait_done_a("t4_done");

        // 4b: completion at count 20 beats timeout
        do_reset();
        start_run();
        repeat (20) tick();
        pass = 4'hF;
        tick();
        pass = '0;
        chk("t4b_status", status_a, 2'b01);
        chk("t4b_cnt", cnt_a, 20);
        wait_done_a("t4b_done");
        max_cycles = '0;

        // 5: asynchronous reset mid-RUN
        do_reset();
        start_run();
        pass = 4'b0001;
        tick();
        pass = '0;
        repeat (3) tick();
        chk("t5_pre_chdone", ch_done_a, 4'b0001);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_chdone", ch_done_a, 0);
        chk("t5_async_cnt", cnt_a, 0);
        chk("t5_async_status", status_a, 0);
        rst = 1'b0;
        start_run();
        chk("t5_restart_cnt", cnt_a, 0);
        tick();
        chk("t5_count1", cnt_a, 1);
        chk("t5_restart_chdone", ch_done_a, 0);

`ifdef TEST_MON_DRAIN_EN
        // 6: fail during DRAIN leaves the verdict alone
        do_reset();
        start_run();
        pass = 4'hF;
        tick();
        pass = '0;
        chk("t6_status", status_a, 2'b01);
        chk("t6_done_pre", done_a, 0);
        fail = 4'hF;
        tick();
        fail = '0;
        chk("t6_status_drain", status_a, 2'b01);
        repeat (DRAIN_LAT - 2) tick();
        chk("t6_done_last", done_a, 0);
        tick();
        chk("t6_done", done_a, 1);
        chk("t6_status_final", status_a, 2'b01);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/test_status_monitor.md
Name: test_status_monitor

Overview:
- Synthesizable, parametrised successor to the bench-level pass/fail/exit detection.
- Watches NUM_CH independent test channels (one per hart or subsystem). Each channel has pass, fail and exit handshakes.
- Latches each channel's first report and aggregates them into one verdict.
- Adds a programmable cycle watchdog, first-failure capture and a completion cycle count. Sits between the core subsystems and the bench/SoC status logic.

Parameters:
- NUM_CH, 4: number of monitored channels (1..32).
- VAL_W, 32: exit value width.
- CNT_W, 32: cycle counter width.
- STOP_ON_FAIL, 1: 1 = finish on the first failure; 0 = wait until all channels have reported.
- DRAIN_CYCLES, 8: done delay used only with TEST_MON_DRAIN_EN (1..255).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  starts monitoring (IDLE->RUN).
- max_cycles_i  in  CNT_W  watchdog limit; 0 = no limit.
- pass_i  in  NUM_CH  per-channel pass pulse/level.
- fail_i  in  NUM_CH  per-channel fail pulse/level.
- exit_valid_i  in  NUM_CH  per-channel exit strobe.
- exit_value_i  in  NUM_CH*VAL_W  exit values; channel k is at bits [k*VAL_W +: VAL_W].
- ch_done_o  out  NUM_CH  sticky per-channel "reported" flags.
- done_o  out  1  verdict final.
- status_o  out  2  00 none, 01 pass, 10 fail, 11 timeout.
- fail_ch_o  out  max(1,$clog2(NUM_CH))  index of first failing channel.
- fail_value_o  out  VAL_W  value of first failure.
- cycle_cnt_o  out  CNT_W  RUN cycles elapsed; frozen at completion.

Behaviour:
- Reset (rst_i high, asynchronous): all outputs 0, state IDLE, all per-channel latches cleared. Applies immediately, including mid-RUN or in DONE.
- IDLE:
  - All channel inputs ignored, cycle_cnt_o held at 0.
  - enable_i sampled high at a rising edge -> RUN.
- RUN:
  - cycle_cnt_o increments by 1 each edge and saturates at all-ones.
  - enable_i is ignored once RUN is entered.
- Channel report: at each RUN edge, for channel k with ch_done_o[k]=0:
  - fail_i[k] -> failed, value = all-ones.
  - Otherwise exit_valid_i[k] with value != 0 -> failed, value = exit value.
  - Otherwise exit_valid_i[k] with value = 0 -> passed.
  - Otherwise pass_i[k] -> passed.
  - Priority on the same cycle: fail_i > exit_valid_i > pass_i.
  - ch_done_o[k] is set on that edge. Later inputs on that channel are ignored (first report wins).
- First failure:
  - fail_ch_o/fail_value_o latch on the first edge on which any channel fails.
  - If several channels fail on the same edge, the lowest index wins.
  - Never overwritten afterwards until reset.
- Completion, evaluated on the same edge using the newly updated flags:
  - STOP_ON_FAIL=1 and any failure -> DONE, status 10.
  - All NUM_CH flags set -> DONE, status 01 if no failure, else 10.
- Timeout:
  - max_cycles_i != 0 and cycle_cnt_o >= max_cycles_i at an edge with no completion -> DONE, status 11.
  - Completion on the same edge wins over timeout.
  - max_cycles_i may change at any time; the comparison uses the current value.
- DONE:
  - Terminal until reset.
  - All outputs frozen; done_o=1 from the edge that enters DONE.
  - Latency: a report sampled at edge N gives done_o/status_o valid after edge N.
- status_o stays 00 while in IDLE/RUN.

Optional Feature:
- TEST_MON_DRAIN_EN defined:
  - An extra DRAIN state sits between RUN and DONE.
  - status_o, fail_* and cycle_cnt_o freeze on entry to DRAIN.
  - A drain counter counts DRAIN_CYCLES edges, then done_o rises. Purpose: the trace/log flushes before the bench terminates.
  - Channel inputs are ignored in DRAIN.
  - Reset during DRAIN clears everything.
- Not defined: no DRAIN state and no drain counter; done_o rises on the edge that freezes status.

Test Plan:
1. NUM_CH=4, STOP_ON_FAIL=1, max=0. pass_i bits 0,1,2,3 pulsed on RUN cycles 3,5,5,9 -> ch_done_o=4'hF, status_o=01, done_o=1 after cycle-9 edge; cycle_cnt_o frozen.
2. exit_valid_i[2] with value 5 and fail_i[1] on the same edge -> status_o=10, fail_ch_o=1, fail_value_o=FFFF_FFFF. done_o rises the next edge; later pass_i has no effect.
3. STOP_ON_FAIL=0: ch0 exits with value 7, then ch1..3 pass 10 cycles later -> done_o held low until the last report; then status_o=10, fail_ch_o=0, fail_value_o=7.
4. max_cycles_i=20, no reports -> timeout at cycle_cnt_o=20: status_o=11, done_o=1. Repeat with all channels passing exactly at count 20 -> status_o=01.
5. rst_i asserted asynchronously mid-RUN (between edges) -> all outputs 0 immediately. Re-enable -> ch_done_o cleared and counting restarts from 0.
6. With TEST_MON_DRAIN_EN, DRAIN_CYCLES=8: all channels pass -> status_o=01 immediately, done_o exactly 8 edges later. fail_i pulsed during DRAIN -> status unchanged.
